// File: rtl/mult16_arbiter_if.sv
// mult16_arbiter_if: requester and multiplier signals of the two-port multiply arbiter.
//   Requester side : req0/req1, a0/b0/a1/b1 in; ack0/ack1, res, err, busy out
//   Multiplier side: mult_op, mult_a, mult_b, mult_reset out; mult_out, mult_ready in
//   modport slave  : the arbiter
//   modport master : the environment (requesters and multiplier)
interface mult16_arbiter_if;
   logic        req0, req1;
   logic [15:0] a0, b0, a1, b1;
   logic        ack0, ack1;
   logic [31:0] res;
   logic        err, busy;
   logic [1:0]  mult_op;
   logic [15:0] mult_a, mult_b;
   logic        mult_reset;
   logic [31:0] mult_out;
   logic        mult_ready;
   modport slave (
      input  req0, req1, a0, b0, a1, b1, mult_out, mult_ready,
      output ack0, ack1, res, err, busy, mult_op, mult_a, mult_b, mult_reset
   );
   modport master (
      output req0, req1, a0, b0, a1, b1, mult_out, mult_ready,
      input  ack0, ack1, res, err, busy, mult_op, mult_a, mult_b, mult_reset
   );
endinterface

// File: rtl/mult16_arbiter.sv
// mult16_arbiter: round-robin arbiter sharing one 16x16 multiplier between two requesters.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mult16_arbiter_if.slave (requests/operands/acks/result, multiplier control)
//   Build option MULT_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYCLES cycles that
//   finishes the operation with res=0 and err pulsed alongside the ack.
module mult16_arbiter #(
   parameter int TIMEOUT_CYCLES = 40
) (
   input logic              clk,
   input logic              rst_n,
   mult16_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
   state_t      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        prio_q, prio_d;
   logic [31:0] res_q, res_d;
   logic [15:0] mult_a_q, mult_a_d;
   logic [15:0] mult_b_q, mult_b_d;
`ifdef MULT_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
   logic            wd_hit;
   assign wd_hit = wd_q == WD_W'(TIMEOUT_CYCLES - 1);
`endif
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      prio_d   = prio_q;
      res_d    = res_q;
      mult_a_d = mult_a_q;
      mult_b_d = mult_b_q;
      case (state_q)
         IDLE: if (bus.req0 | bus.req1) begin
            // prio_q names the requester that wins a tie
            gnt_d    = (bus.req0 & bus.req1) ? prio_q : bus.req1;
            mult_a_d = gnt_d ? bus.a1 : bus.a0;
            mult_b_d = gnt_d ? bus.b1 : bus.b0;
            state_d  = START;
         end
         START: state_d = WAIT;
         WAIT: begin
            if (bus.mult_ready) begin
               res_d   = bus.mult_out;
               state_d = DONE;
            end
`ifdef MULT_ARB_TIMEOUT_EN
            else if (wd_hit) begin
               res_d   = '0;
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            prio_d  = ~gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
`ifdef MULT_ARB_TIMEOUT_EN
   always_comb begin
      wd_d  = (state_q == WAIT) ? WD_W'(wd_q + 1'b1) : '0;
      // every DONE is entered from WAIT, so err_q is refreshed there and held through DONE
      err_d = (state_q == WAIT) ? (wd_hit & ~bus.mult_ready) : err_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end
   assign bus.err = (state_q == DONE) & err_q;
`else
   assign bus.err = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= 1'b0;
         prio_q   <= 1'b0;
         res_q    <= '0;
         mult_a_q <= '0;
         mult_b_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         prio_q   <= prio_d;
         res_q    <= res_d;
         mult_a_q <= mult_a_d;
         mult_b_q <= mult_b_d;
      end
   end
   assign bus.ack0       = (state_q == DONE) & ~gnt_q;
   assign bus.ack1       = (state_q == DONE) & gnt_q;
   assign bus.busy       = state_q != IDLE;
   assign bus.mult_op    = (state_q == START || state_q == WAIT) ? 2'b01 : 2'b00;
   assign bus.mult_reset = state_q != WAIT;
   assign bus.res        = res_q;
   assign bus.mult_a     = mult_a_q;
   assign bus.mult_b     = mult_b_q;
endmodule

// File: tb/tb_mult16_arbiter.sv
// tb_mult16_arbiter: directed self-checking bench for mult16_arbiter.
module tb_mult16_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   mult16_arbiter_if bus();
   mult16_arbiter #(.TIMEOUT_CYCLES(40)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   assign bus.mult_out = {16'h0, bus.mult_a} * {16'h0, bus.mult_b};

   task automatic clear_inputs();
      bus.req0 = 0; bus.req1 = 0;
      bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
      bus.mult_ready = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic finish_op(input int extra, output logic k0, output logic k1,
                            output logic er, output logic [31:0] r, output bit hung);
      int n = 0;
      while (!(bus.busy && !bus.mult_reset) && n < 8) begin
         @(negedge clk);
         n++;
      end
      hung = !(bus.busy && !bus.mult_reset);
      repeat (extra) @(negedge clk);
      bus.mult_ready = 1;
      @(negedge clk);
      k0 = bus.ack0; k1 = bus.ack1; er = bus.err; r = bus.res;
      bus.mult_ready = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      @(negedge clk);
      total++; if ({bus.ack0, bus.ack1, bus.err, bus.busy} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {bus.ack0, bus.ack1, bus.err, bus.busy}); end
      total++; if (bus.res !== 32'd0) begin bad++; $display("FAIL reset_res: got %h want 0", bus.res); end
      total++; if ({bus.mult_a, bus.mult_b} !== 32'd0) begin bad++; $display("FAIL reset_operands: got %h want 0", {bus.mult_a, bus.mult_b}); end
      total++; if ({bus.mult_op, bus.mult_reset} !== 3'b001) begin bad++; $display("FAIL reset_mult_ctrl: got %b want 001", {bus.mult_op, bus.mult_reset}); end
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_single();
      do_reset();
      bus.a0 = 16'd300; bus.b0 = 16'd7; bus.req0 = 1;
      @(negedge clk);
      total++; if ({bus.mult_a, bus.mult_b} !== {16'd300, 16'd7}) begin bad++; $display("FAIL single_operands: got %h want %h", {bus.mult_a, bus.mult_b}, {16'd300, 16'd7}); end
      total++; if ({bus.busy, bus.mult_op, bus.mult_reset} !== 4'b1011) begin bad++; $display("FAIL single_start: got %b want 1011", {bus.busy, bus.mult_op, bus.mult_reset}); end
      @(negedge clk);
      total++; if ({bus.busy, bus.mult_op, bus.mult_reset} !== 4'b1010) begin bad++; $display("FAIL single_wait: got %b want 1010", {bus.busy, bus.mult_op, bus.mult_reset}); end
      bus.mult_ready = 1;
      @(negedge clk);
      total++; if ({bus.ack0, bus.ack1, bus.err} !== 3'b100) begin bad++; $display("FAIL single_ack: got %b want 100", {bus.ack0, bus.ack1, bus.err}); end
      total++; if (bus.res !== 32'd2100) begin bad++; $display("FAIL single_res: got %0d want 2100", bus.res); end
      total++; if ({bus.mult_op, bus.mult_reset} !== 3'b001) begin bad++; $display("FAIL single_done_ctrl: got %b want 001", {bus.mult_op, bus.mult_reset}); end
      bus.mult_ready = 0; bus.req0 = 0;
      @(negedge clk);
      total++; if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000) begin bad++; $display("FAIL single_idle: got %b want 000", {bus.ack0, bus.ack1, bus.busy}); end
      total++; if (bus.res !== 32'd2100) begin bad++; $display("FAIL single_res_hold: got %0d want 2100", bus.res); end
   endtask

   task automatic test_both();
      logic k0, k1, er;
      logic [31:0] r;
      bit hung;
      do_reset();
      bus.a0 = 16'd3; bus.b0 = 16'd5; bus.a1 = 16'hFFFF; bus.b1 = 16'hFFFF;
      bus.req0 = 1; bus.req1 = 1;
      finish_op(0, k0, k1, er, r, hung);
      total++; if ({hung, k0, k1} !== 3'b010) begin bad++; $display("FAIL both_first_ack: got %b want 010", {hung, k0, k1}); end
      total++; if (r !== 32'd15) begin bad++; $display("FAIL both_first_res: got %h want 0000000f", r); end
      bus.req0 = 0;
      @(negedge clk);
      total++; if ({bus.busy, bus.ack0, bus.ack1} !== 3'b000) begin bad++; $display("FAIL both_idle_gap: got %b want 000", {bus.busy, bus.ack0, bus.ack1}); end
      finish_op(0, k0, k1, er, r, hung);
      total++; if ({hung, k0, k1} !== 3'b001) begin bad++; $display("FAIL both_second_ack: got %b want 001", {hung, k0, k1}); end
      total++; if (r !== 32'hFFFE0001) begin bad++; $display("FAIL both_second_res: got %h want fffe0001", r); end
      bus.req1 = 0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic k0, k1, er;
      logic [31:0] r;
      bit hung;
      logic exp0;
      do_reset();
      bus.a0 = 16'd2; bus.b0 = 16'd3; bus.a1 = 16'd4; bus.b1 = 16'd5;
      bus.req0 = 1; bus.req1 = 1;
      for (int i = 0; i < 4; i++) begin
         exp0 = (i % 2) == 0;
         finish_op(i, k0, k1, er, r, hung);
         total++; if ({hung, k0, k1} !== {1'b0, exp0, ~exp0}) begin bad++; $display("FAIL rr_grant_%0d: got %b want %b", i, {hung, k0, k1}, {1'b0, exp0, ~exp0}); end
         total++; if (r !== (exp0 ? 32'd6 : 32'd20)) begin bad++; $display("FAIL rr_res_%0d: got %0d want %0d", i, r, exp0 ? 6 : 20); end
      end
      bus.req0 = 0; bus.req1 = 0;
      @(negedge clk);
   endtask

   task automatic test_latency();
      do_reset();
      bus.a1 = 16'd12; bus.b1 = 16'd11; bus.req1 = 1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         total++; if ({bus.mult_reset, bus.mult_op, bus.ack1} !== 4'b0010) begin bad++; $display("FAIL latency_wait_%0d: got %b want 0010", i, {bus.mult_reset, bus.mult_op, bus.ack1}); end
         @(negedge clk);
      end
      bus.mult_ready = 1;
      @(negedge clk);
      total++; if ({bus.ack0, bus.ack1} !== 2'b01) begin bad++; $display("FAIL latency_ack: got %b want 01", {bus.ack0, bus.ack1}); end
      total++; if (bus.res !== 32'd132) begin bad++; $display("FAIL latency_res: got %0d want 132", bus.res); end
      bus.mult_ready = 0; bus.req1 = 0;
      @(negedge clk);
      total++; if (bus.ack1 !== 1'b0) begin bad++; $display("FAIL latency_ack_pulse: got %b want 0", bus.ack1); end
   endtask

   task automatic test_ignore_ready();
      do_reset();
      bus.mult_ready = 1;
      repeat (3) begin
         @(negedge clk);
         total++; if ({bus.busy, bus.ack0, bus.ack1} !== 3'b000) begin bad++; $display("FAIL ignore_idle: got %b want 000", {bus.busy, bus.ack0, bus.ack1}); end
      end
      bus.a0 = 16'd10; bus.b0 = 16'd10; bus.req0 = 1;
      @(negedge clk);
      @(negedge clk);
      total++; if ({bus.ack0, bus.mult_reset} !== 2'b00) begin bad++; $display("FAIL ignore_start: got %b want 00", {bus.ack0, bus.mult_reset}); end
      @(negedge clk);
      total++; if ({bus.ack0, bus.res} !== {1'b1, 32'd100}) begin bad++; $display("FAIL ignore_ack: got %h want %h", {bus.ack0, bus.res}, {1'b1, 32'd100}); end
      bus.mult_ready = 0; bus.req0 = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic k0, k1, er;
      logic [31:0] r;
      bit hung;
      int seen = 0;
      do_reset();
      bus.a1 = 16'd7; bus.b1 = 16'd6; bus.req1 = 1;
      finish_op(0, k0, k1, er, r, hung);
      total++; if ({hung, k1, r} !== {1'b0, 1'b1, 32'd42}) begin bad++; $display("FAIL midrst_pre_op: got %h want %h", {hung, k1, r}, {1'b0, 1'b1, 32'd42}); end
      bus.req1 = 0;
      @(negedge clk);
      bus.a0 = 16'd9; bus.b0 = 16'd9; bus.req0 = 1;
      @(negedge clk);
      @(negedge clk);
      total++; if (bus.mult_reset !== 1'b0) begin bad++; $display("FAIL midrst_in_wait: got %b want 0", bus.mult_reset); end
      rst_n = 0;
      #1;
      total++; if ({bus.busy, bus.ack0, bus.ack1, bus.err, bus.mult_op, bus.mult_reset} !== 7'b0000001) begin bad++; $display("FAIL midrst_ctrl: got %b want 0000001", {bus.busy, bus.ack0, bus.ack1, bus.err, bus.mult_op, bus.mult_reset}); end
      total++; if ({bus.res, bus.mult_a, bus.mult_b} !== 64'd0) begin bad++; $display("FAIL midrst_data: got %h want 0", {bus.res, bus.mult_a, bus.mult_b}); end
      bus.req0 = 0; bus.mult_ready = 1;
      @(negedge clk);
      rst_n = 1;
      repeat (6) begin
         @(negedge clk);
         if (bus.ack0 || bus.ack1 || bus.busy) seen++;
      end
      bus.mult_ready = 0;
      total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_ack: got %0d active cycles want 0", seen); end
   endtask

   task automatic test_timeout();
      logic k0, k1, er;
      logic [31:0] r;
      bit hung;
      int n = 0;
      do_reset();
      bus.a0 = 16'd5; bus.b0 = 16'd5; bus.req0 = 1;
      finish_op(0, k0, k1, er, r, hung);
      total++; if ({hung, k0, er, r} !== {1'b0, 1'b1, 1'b0, 32'd25}) begin bad++; $display("FAIL wd_pre_op: got %h want %h", {hung, k0, er, r}, {1'b0, 1'b1, 1'b0, 32'd25}); end
      bus.req0 = 0;
      @(negedge clk);
      bus.a0 = 16'd6; bus.b0 = 16'd6; bus.req0 = 1;
      @(negedge clk);
`ifdef MULT_ARB_TIMEOUT_EN
      while (!bus.ack0 && n < 100) begin
         if (!bus.mult_reset) n++;
         @(negedge clk);
      end
      total++; if (n !== 40) begin bad++; $display("FAIL wd_wait_cycles: got %0d want 40", n); end
      total++; if ({bus.ack0, bus.err, bus.res} !== {1'b1, 1'b1, 32'd0}) begin bad++; $display("FAIL wd_expire: got %h want %h", {bus.ack0, bus.err, bus.res}, {1'b1, 1'b1, 32'd0}); end
      bus.req0 = 0;
      @(negedge clk);
      total++; if ({bus.ack0, bus.err} !== 2'b00) begin bad++; $display("FAIL wd_err_pulse: got %b want 00", {bus.ack0, bus.err}); end
`else
      repeat (60) begin
         @(negedge clk);
         if (bus.ack0 || bus.ack1 || bus.err) n++;
      end
      total++; if ({n, bus.mult_reset} !== {32'd0, 1'b0}) begin bad++; $display("FAIL nowd_waits: got %h want %h", {n, bus.mult_reset}, {32'd0, 1'b0}); end
      bus.mult_ready = 1;
      @(negedge clk);
      total++; if ({bus.ack0, bus.err, bus.res} !== {1'b1, 1'b0, 32'd36}) begin bad++; $display("FAIL nowd_ack: got %h want %h", {bus.ack0, bus.err, bus.res}, {1'b1, 1'b0, 32'd36}); end
      bus.mult_ready = 0; bus.req0 = 0;
      @(negedge clk);
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_both();
      test_round_robin();
      test_latency();
      test_ignore_ready();
      test_reset_mid();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
      $fatal(1, "bench time limit reached");
   end
endmodule
